cursor_overlay: RTL

//  Draws the cursor on the VGA stream using the cursor_x/cursor_y/cursor_size position produced upstream.

---
 rtl/cursor_overlay.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cursor_overlay.sv
// Composites a square cursor onto the VGA pixel stream through a 2-stage pipeline.
// Cursor position and size are latched at frame start so the cursor never tears.
module cursor_overlay #(
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [11:0] FILL_COLOR   = 12'hFFF,
    parameter logic [11:0] BORDER_COLOR = 12'h000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_en,
    input  logic        i_frame_start,
    input  logic [9:0]  i_h_count,
    input  logic [9:0]  i_v_count,
    input  logic        i_active_video,
    input  logic [11:0] i_in_rgb,
    input  logic [9:0]  i_cursor_x,
    input  logic [9:0]  i_cursor_y,
    input  logic [1:0]  i_cursor_size,
    output logic [11:0] o_out_rgb,
    output logic        o_out_active,
    output logic        o_cursor_hit
);

    localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] LAST = (BLINK_FRAMES > 1) ? CW'(BLINK_FRAMES - 1) : '0;

    logic [9:0]    r_sx;
    logic [9:0]    r_sy;
    logic [1:0]    r_ssize;
    logic [CW-1:0] r_blink_cnt;
    logic          r_visible;

    logic          r_s1_inside;
    logic          r_s1_edge;
    logic          r_s1_active;
    logic [11:0]   r_s1_rgb;

    logic [11:0]   r_out_rgb;
    logic          r_out_active;
    logic          r_out_hit;

    logic          w_capture;
    logic          w_hidden;
    logic [10:0]   w_size;
    logic [10:0]   w_x0;
    logic [10:0]   w_x1;
    logic [10:0]   w_y0;
    logic [10:0]   w_y1;
    logic [10:0]   w_h;
    logic [10:0]   w_v;
    logic          w_inside;
    logic          w_edge;
    logic          w_hit;
    logic [11:0]   w_rgb;

    assign w_capture = i_pix_en && i_frame_start;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sx    <= 10'd320;
            r_sy    <= 10'd240;
            r_ssize <= 2'b00;
        end else if (w_capture) begin
            r_sx    <= i_cursor_x;
            r_sy    <= i_cursor_y;
            r_ssize <= i_cursor_size;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_blink_cnt <= '0;
            r_visible   <= 1'b1;
        end else if (w_capture && BLINK_FRAMES != 0) begin
            if (r_blink_cnt == LAST) begin
                r_blink_cnt <= '0;
                r_visible   <= ~r_visible;
            end else begin
                r_blink_cnt <= r_blink_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        w_size   = 11'd20;
        w_hidden = 1'b0;
        unique case (r_ssize)
            2'b00:   w_size = 11'd4;
            2'b01:   w_size = 11'd8;
            2'b10:   w_size = 11'd20;
            default: w_hidden = 1'b1;
        endcase
    end

    // 11-bit bounds so a cursor near column 1023 cannot wrap to 0
    assign w_h  = {1'b0, i_h_count};
    assign w_v  = {1'b0, i_v_count};
    assign w_x0 = {1'b0, r_sx};
    assign w_y0 = {1'b0, r_sy};
    assign w_x1 = w_x0 + w_size - 11'd1;
    assign w_y1 = w_y0 + w_size - 11'd1;

    assign w_inside = !w_hidden
                   && (w_h >= w_x0) && (w_h <= w_x1)
                   && (w_v >= w_y0) && (w_v <= w_y1);

    assign w_edge = w_inside
                 && ((w_h == w_x0) || (w_h == w_x1)
                 ||  (w_v == w_y0) || (w_v == w_y1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_inside <= 1'b0;
            r_s1_edge   <= 1'b0;
            r_s1_active <= 1'b0;
            r_s1_rgb    <= 12'h000;
        end else if (i_pix_en) begin
            r_s1_inside <= w_inside;
            r_s1_edge   <= w_edge;
            r_s1_active <= i_active_video;
            r_s1_rgb    <= i_in_rgb;
        end
    end

    assign w_hit = r_s1_inside && r_visible && r_s1_active;

    always_comb begin
        w_rgb = r_s1_rgb;
        if (!r_s1_active) begin
            w_rgb = 12'h000;
        end else if (w_hit) begin
            w_rgb = r_s1_edge ? BORDER_COLOR : FILL_COLOR;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_rgb    <= 12'h000;
            r_out_active <= 1'b0;
            r_out_hit    <= 1'b0;
        end else if (i_pix_en) begin
            r_out_rgb    <= w_rgb;
            r_out_active <= r_s1_active;
            r_out_hit    <= w_hit;
        end
    end

    assign o_out_rgb    = r_out_rgb;
    assign o_out_active = r_out_active;
    assign o_cursor_hit = r_out_hit;

endmodule
